// File: rtl/quad_pkg.sv
// Shared widths, state encoding and velocity limits for the quadrature
// velocity path.
package quad_pkg;

  localparam int DEF_COUNT_W  = 32;
  localparam int DEF_PERIOD_W = 24;
  localparam int DEF_VEL_W    = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic signed [DEF_VEL_W-1:0] VEL_MAX = {1'b0, {(DEF_VEL_W-1){1'b1}}};
  localparam logic signed [DEF_VEL_W-1:0] VEL_MIN = {1'b1, {(DEF_VEL_W-1){1'b0}}};

endpackage

// File: rtl/quad_sat.sv
// Combinational signed narrowing saturator: clamps a signed IN_W value into
// the signed OUT_W range and flags when clamping happened.
module quad_sat #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 16
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout,
  output logic                    sat
);

  localparam logic signed [IN_W-1:0] HI_IN = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] LO_IN = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  // clamp to the output range, pass through otherwise
  always_comb begin
    dout = din[OUT_W-1:0];
    sat  = 1'b0;
    if (din > HI_IN) begin
      dout = {1'b0, {(OUT_W-1){1'b1}}};
      sat  = 1'b1;
    end else if (din < LO_IN) begin
      dout = {1'b1, {(OUT_W-1){1'b0}}};
      sat  = 1'b1;
    end
  end

endmodule

// File: rtl/quadrature_velocity.sv
// Windowed velocity measurement on a 32-bit quadrature position count.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | timer parked at 0; waiting for ENABLE to take a baseline
//   ST_RUN  | counting the window; a tick samples COUNT and emits a delta
//
// The output register is a single-entry valid/ready slot. A tick that finds
// the slot occupied and not being drained drops its sample and sets OVERRUN,
// but the baseline still advances so the next window stays correct.
module quadrature_velocity
  import quad_pkg::*;
#(
  parameter int COUNT_W  = DEF_COUNT_W,
  parameter int PERIOD_W = DEF_PERIOD_W,
  parameter int VEL_W    = DEF_VEL_W
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [COUNT_W-1:0]      COUNT,
  input  logic                    ENABLE,
  input  logic [PERIOD_W-1:0]     PERIOD,
  output logic                    VEL_VALID,
  input  logic                    VEL_READY,
  output logic signed [VEL_W-1:0] VELOCITY,
  output logic [COUNT_W-1:0]      POSITION,
  output logic                    SAT,
  output logic                    OVERRUN
);

  state_e               state_q, state_d;
  logic [PERIOD_W-1:0]  timer_q, timer_d;
  logic [COUNT_W-1:0]   last_q, last_d;
  logic                 vel_valid_q, vel_valid_d;
  logic [VEL_W-1:0]     velocity_q, velocity_d;
  logic [COUNT_W-1:0]   position_q, position_d;
  logic                 sat_q, sat_d;
  logic                 overrun_q, overrun_d;

  logic [PERIOD_W-1:0]     last_tick_at;
  logic                    tick;
  logic [COUNT_W-1:0]      raw;
  logic signed [VEL_W-1:0] vel_sat;
  logic                    vel_clamped;

  // window end: PERIOD of 0 behaves like 1, so the tick compare is against 0
  always_comb begin
    last_tick_at = (PERIOD == '0) ? '0 : PERIOD - PERIOD_W'(1);
    tick         = (state_q == ST_RUN) && ENABLE && (timer_q >= last_tick_at);
    raw          = COUNT - last_q;
  end

  quad_sat #(
    .IN_W  (COUNT_W),
    .OUT_W (VEL_W)
  ) u_sat (
    .din  (signed'(raw)),
    .dout (vel_sat),
    .sat  (vel_clamped)
  );

  // next-state, window timer, baseline and output-slot logic
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    last_d      = last_q;
    vel_valid_d = vel_valid_q;
    velocity_d  = velocity_q;
    position_d  = position_q;
    sat_d       = sat_q;
    overrun_d   = overrun_q;

    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if (ENABLE) begin
          last_d  = COUNT;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!ENABLE) begin
          state_d   = ST_IDLE;
          timer_d   = '0;
          overrun_d = 1'b0;
        end else if (tick) begin
          timer_d = '0;
          last_d  = COUNT;
        end else begin
          timer_d = timer_q + PERIOD_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase

    if (tick) begin
      if (!vel_valid_q || VEL_READY) begin
        vel_valid_d = 1'b1;
        velocity_d  = vel_sat;
        position_d  = COUNT;
        sat_d       = vel_clamped;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (vel_valid_q && VEL_READY) begin
      vel_valid_d = 1'b0;
    end
  end

  // state and output registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      last_q      <= '0;
      vel_valid_q <= 1'b0;
      velocity_q  <= '0;
      position_q  <= '0;
      sat_q       <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      last_q      <= last_d;
      vel_valid_q <= vel_valid_d;
      velocity_q  <= velocity_d;
      position_q  <= position_d;
      sat_q       <= sat_d;
      overrun_q   <= overrun_d;
    end
  end

  assign VEL_VALID = vel_valid_q;
  assign VELOCITY  = velocity_q;
  assign POSITION  = position_q;
  assign SAT       = sat_q;
  assign OVERRUN   = overrun_q;

endmodule

// File: tb/tb_quadrature_velocity.sv
// Scoreboard bench for quadrature_velocity: a window-level reference model
// pushes expected samples, a negedge monitor pops them on each handshake.
module tb_quadrature_velocity;

  logic               CLK = 1'b0;
  logic               RST = 1'b1;
  logic [31:0]        COUNT = '0;
  logic               ENABLE = 1'b0;
  logic [23:0]        PERIOD = '0;
  logic               VEL_VALID;
  logic               VEL_READY = 1'b0;
  logic signed [15:0] VELOCITY;
  logic [31:0]        POSITION;
  logic               SAT;
  logic               OVERRUN;

  quadrature_velocity dut (
    .CLK       (CLK),
    .RST       (RST),
    .COUNT     (COUNT),
    .ENABLE    (ENABLE),
    .PERIOD    (PERIOD),
    .VEL_VALID (VEL_VALID),
    .VEL_READY (VEL_READY),
    .VELOCITY  (VELOCITY),
    .POSITION  (POSITION),
    .SAT       (SAT),
    .OVERRUN   (OVERRUN)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] vel;
    logic [31:0] pos;
    logic        sat;
  } samp_t;

  samp_t q[$];

  int total = 0;
  int bad   = 0;
  int n_pop = 0;

  // reference model: windows measured in elapsed clocks since baseline
  bit          m_run   = 0;
  int unsigned m_el    = 0;
  logic [31:0] m_last  = '0;
  bit          m_valid = 0;
  bit          m_ovr   = 0;
  bit          exp_valid_now = 0;
  bit          exp_ovr_now   = 0;
  bit          mon_en = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit rst, input bit en, input logic [31:0] cnt,
                      input logic [23:0] per, input bit rdy);
    bit          tick;
    int unsigned eff;
    logic [31:0] diff;
    int          d;
    samp_t       s;
    @(posedge CLK);
    #2;
    exp_valid_now = m_valid;
    exp_ovr_now   = m_ovr;
    RST = rst; ENABLE = en; COUNT = cnt; PERIOD = per; VEL_READY = rdy;
    tick = 0;
    s.vel = '0; s.pos = '0; s.sat = 1'b0;
    if (rst) begin
      m_run = 0; m_el = 0; m_last = '0; m_valid = 0; m_ovr = 0;
      q.delete();
    end else begin
      if (!m_run) begin
        if (en) begin
          m_last = cnt; m_run = 1; m_el = 0;
        end
      end else if (!en) begin
        m_run = 0; m_el = 0; m_ovr = 0;
      end else begin
        eff = (per == 0) ? 1 : int'(per);
        if (m_el + 1 >= eff) begin
          tick = 1;
          diff = cnt - m_last;
          d = signed'(diff);
          if (d > 32767) begin
            s.vel = 16'h7FFF; s.sat = 1'b1;
          end else if (d < -32768) begin
            s.vel = 16'h8000; s.sat = 1'b1;
          end else begin
            s.vel = d[15:0]; s.sat = 1'b0;
          end
          s.pos  = cnt;
          m_last = cnt;
          m_el   = 0;
        end else begin
          m_el++;
        end
      end
      if (tick) begin
        if (!m_valid || rdy) begin
          q.push_back(s);
          m_valid = 1;
        end else begin
          m_ovr = 1;
        end
      end else if (m_valid && rdy) begin
        m_valid = 0;
      end
    end
  endtask

  // monitor: compare outputs half a cycle after each edge
  initial begin
    bit          rst_prev = 0;
    bit          hold_prev = 0;
    logic [15:0] h_vel;
    logic [31:0] h_pos;
    logic        h_sat;
    samp_t       e;
    forever begin
      @(negedge CLK);
      if (mon_en) begin
        chk("vel_valid", {63'd0, VEL_VALID}, {63'd0, exp_valid_now});
        chk("overrun", {63'd0, OVERRUN}, {63'd0, exp_ovr_now});
        if (rst_prev) begin
          chk("rst_velocity", {48'd0, VELOCITY}, 64'd0);
          chk("rst_position", {32'd0, POSITION}, 64'd0);
          chk("rst_sat", {63'd0, SAT}, 64'd0);
        end
        if (hold_prev && VEL_VALID) begin
          chk("hold_velocity", {48'd0, VELOCITY}, {48'd0, h_vel});
          chk("hold_position", {32'd0, POSITION}, {32'd0, h_pos});
          chk("hold_sat", {63'd0, SAT}, {63'd0, h_sat});
        end
        if (VEL_VALID && VEL_READY && !RST) begin
          if (q.size() == 0) begin
            chk("unexpected_sample", 64'd1, 64'd0);
          end else begin
            e = q.pop_front();
            n_pop++;
            chk("velocity", {48'd0, VELOCITY}, {48'd0, e.vel});
            chk("position", {32'd0, POSITION}, {32'd0, e.pos});
            chk("sat", {63'd0, SAT}, {63'd0, e.sat});
          end
        end
      end
      rst_prev  = RST;
      hold_prev = VEL_VALID && !VEL_READY && !RST;
      h_vel = VELOCITY; h_pos = POSITION; h_sat = SAT;
    end
  end

  initial begin
    logic [31:0] c;
    logic [23:0] per;
    logic [31:0] wrap_seq [8];
    logic [23:0] per_pick [6];
    bit          rst_r, en_r, rdy_r;
    int          st;

    wrap_seq = '{32'hFFFF_FFFF, 32'h0, 32'h1, 32'h1,
                 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
    per_pick = '{24'd0, 24'd1, 24'd2, 24'd3, 24'd7, 24'd20};
    c = 32'd1000;

    step(1, 0, c, 0, 0);
    step(1, 0, c, 0, 0);
    mon_en = 1;

    // basic rate: +1 every 4 clocks over 100-clock windows
    for (int i = 0; i < 450; i++) begin
      if (i % 4 == 3) c = c + 1;
      step(0, 1, c, 24'd100, 1);
    end

    // wrap-around across 0xFFFFFFFF in both directions
    step(0, 0, c, 24'd4, 1);
    c = 32'hFFFF_FFFE;
    step(0, 1, c, 24'd4, 1);
    for (int i = 0; i < 8; i++) begin
      c = wrap_seq[i];
      step(0, 1, c, 24'd4, 1);
    end
    for (int i = 0; i < 3; i++) step(0, 1, c, 24'd4, 1);

    // saturation high, low, then small delta
    for (int i = 0; i < 40; i++) begin
      if (i == 3)  c = c + 32'd40000;
      if (i == 13) c = c - 32'd80000;
      if (i == 24) c = c + 32'd5;
      step(0, 1, c, 24'd10, 1);
    end

    // back-pressure then release, overrun cleared by disable
    for (int i = 0; i < 20; i++) begin
      c = c + 32'd2;
      step(0, 1, c, 24'd8, 0);
    end
    for (int i = 0; i < 40; i++) begin
      c = c + 32'd3;
      step(0, 1, c, 24'd8, 1);
    end
    step(0, 0, c, 24'd8, 1);
    step(0, 0, c, 24'd8, 1);

    // PERIOD 0 and 1: a sample every clock
    for (int i = 0; i < 40; i++) begin
      c = c + 32'($urandom_range(0, 6)) - 32'd3;
      step(0, 1, c, (i < 20) ? 24'd0 : 24'd1, 1);
    end

    // PERIOD shrink mid-window
    step(0, 0, c, 24'd1000, 1);
    for (int i = 0; i < 500; i++) begin
      if (i % 7 == 0) c = c + 1;
      step(0, 1, c, 24'd1000, 1);
    end
    for (int i = 0; i < 12; i++) begin
      c = c + 1;
      step(0, 1, c, 24'd5, 1);
    end

    // reset mid-window while a sample is held
    step(0, 0, c, 24'd100, 0);
    for (int i = 0; i < 150; i++) begin
      c = c + 1;
      step(0, 1, c, 24'd100, 0);
    end
    step(1, 1, c, 24'd100, 1);
    step(0, 0, c, 24'd100, 1);

    // disable mid-window, then re-baseline
    for (int i = 0; i < 30; i++) begin
      c = c + 32'd9;
      step(0, 1, c, 24'd20, 1);
    end
    step(0, 0, c + 32'd500, 24'd20, 1);
    c = c + 32'd700;
    for (int i = 0; i < 45; i++) begin
      c = c + 1;
      step(0, 1, c, 24'd20, 1);
    end

    // randomized traffic
    per = 24'd3;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) per = per_pick[$urandom_range(0, 5)];
      rst_r = ($urandom_range(0, 499) == 0);
      en_r  = ($urandom_range(0, 39) != 0);
      rdy_r = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) c = c + $urandom;
      else begin
        st = int'($urandom_range(0, 6)) - 3;
        c = c + 32'(st);
      end
      step(rst_r, en_r, c, per, rdy_r);
    end

    for (int i = 0; i < 4; i++) step(0, 0, c, 24'd1, 1);
    chk("samples_seen", {63'd0, n_pop >= 150}, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
